instruction_fetch_queue: RTL and testbench

Decoupling prefetch buffer between the word-addressed instruction memory and the IF/ID pipeline register. It generates sequential fetch addresses (PC+1 per instruction) and absorbs the memory's one-cycle read latency. Fetched instructions are held in a small FIFO, so the PC keeps running ahead while the decode stage is stalled by the hazard unit. A taken branch resolved in ID redirects the queue, which flushes the buffer and restarts fetch at the branch target.

---
 rtl/instruction_fetch_queue.sv | 74 +++++++
 tb/tb_instruction_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: sequential prefetch FIFO between word-addressed imem and IF/ID, redirected by taken branches.
// Optional FETCH_QUEUE_BYPASS_EN forwards the in-flight word straight to the outputs when the FIFO is empty.
module instruction_fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic clock,
  input  logic reset,
  input  logic redirect,
  input  logic [31:0] redirectPC,
  input  logic hold,
  output logic imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  output logic outValid,
  output logic [31:0] outInstruction,
  output logic [31:0] outPCPlus1,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] fetchPC, pendingPC;
  logic pending;
  logic [AW-1:0] rdPtr, wrPtr;
  logic [AW:0] occ;
  logic [AW+1:0] credit;
  logic [31:0] instMem [DEPTH];
  logic [31:0] pcMem [DEPTH];
  logic fifoValid, bypass, fifoDeq, wrEn;
  assign fifoValid = occ != '0;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = !fifoValid && pending && !redirect;
`else
  assign bypass = 1'b0;
`endif
  // in-flight requests hold credit so a response always has a free slot
  assign credit = {1'b0, occ} + (AW+2)'(pending);
  assign imemReq = reset && !redirect && credit < (AW+2)'(DEPTH);
  assign imemAddr = fetchPC;
  assign outValid = fifoValid || bypass;
  assign outInstruction = bypass ? imemData : fifoValid ? instMem[rdPtr] : '0;
  assign outPCPlus1 = bypass ? pendingPC + 32'd1 : fifoValid ? pcMem[rdPtr] : '0;
  assign count = occ;
  assign fifoDeq = fifoValid && !hold && !redirect;
  assign wrEn = pending && !redirect && !(bypass && !hold);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      fetchPC <= RESET_PC;
      pending <= 1'b0;
      pendingPC <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      occ <= '0;
    end else if (redirect) begin
      fetchPC <= redirectPC;
      pending <= 1'b0;
      rdPtr <= '0;
      wrPtr <= '0;
      occ <= '0;
    end else begin
      pending <= imemReq;
      if (imemReq) begin
        pendingPC <= fetchPC;
        fetchPC <= fetchPC + 32'd1;
      end
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (fifoDeq) rdPtr <= rdPtr + 1'b1;
      occ <= occ + (AW+1)'(wrEn) - (AW+1)'(fifoDeq);
    end
  always_ff @(posedge clock)
    if (wrEn) begin
      instMem[wrPtr] <= imemData;
      pcMem[wrPtr] <= pendingPC + 32'd1;
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: randomized and directed checks of the fetch queue against an in-order PC stream model.
module tb_instruction_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h00000000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0, redirect = 1'b0, hold = 1'b0;
  logic [31:0] redirectPC = '0, imemData = '0, imemAddr, outInstruction, outPCPlus1;
  logic imemReq, outValid;
  logic [$clog2(DEPTH):0] count;
  int total = 0, bad = 0;
  logic [31:0] expPC;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirectPC(redirectPC), .hold(hold),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemData(imemData), .outValid(outValid),
    .outInstruction(outInstruction), .outPCPlus1(outPCPlus1), .count(count));

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // one-cycle-latency instruction memory
  always @(posedge clock) if (imemReq) imemData <= word(imemAddr);

  // the architectural view: heads must come out as consecutive PCs, restarting at each redirect target
  task automatic drive_cycle(input logic r, input logic [31:0] rpc, input logic h);
    redirect = r; redirectPC = rpc; hold = h;
    #2;
    total++;
    if (count > DEPTH || (count == DEPTH && imemReq)) begin
      bad++; $display("FAIL credit count=%0d imemReq=%0b", count, imemReq);
    end
    if (outValid && !h && !r) begin
      total++;
      if (outInstruction !== word(expPC) || outPCPlus1 !== expPC + 32'd1) begin
        bad++; $display("FAIL head got=%h/%h exp=%h/%h", outInstruction, outPCPlus1, word(expPC), expPC + 32'd1);
      end
      expPC = expPC + 32'd1;
    end
    if (r) expPC = rpc;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic restart();
    reset = 1'b0; redirect = 1'b0; hold = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    expPC = RST_PC;
  endtask

  task automatic test_reset();
    @(negedge clock);
    #1;
    total++;
    if (outValid !== 1'b0 || count !== '0 || imemReq !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got v=%0b c=%0d req=%0b exp 0/0/0", outValid, count, imemReq);
    end
    total++;
    if (imemAddr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imemAddr, RST_PC); end
    total++;
    if (outInstruction !== '0 || outPCPlus1 !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h exp=0/0", outInstruction, outPCPlus1);
    end
  endtask

  task automatic test_startup();
    restart();
    #1;
    total++;
    if (imemReq !== 1'b1 || imemAddr !== RST_PC || outValid !== 1'b0) begin
      bad++; $display("FAIL start_e0 got req=%0b addr=%h v=%0b", imemReq, imemAddr, outValid);
    end
    drive_cycle(1'b0, '0, 1'b0);
    total++;
    if (imemAddr !== RST_PC + 32'd1 || outValid !== BYP) begin
      bad++; $display("FAIL start_e1 got addr=%h v=%0b exp %h/%0b", imemAddr, outValid, RST_PC + 32'd1, BYP);
    end
    drive_cycle(1'b0, '0, 1'b0);
    total++;
    if (outValid !== 1'b1 || outPCPlus1 !== (BYP ? 32'd2 : 32'd1)) begin
      bad++; $display("FAIL start_e2 got v=%0b pc1=%h", outValid, outPCPlus1);
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, '0, 1'b0);
      total++;
      if (outValid !== 1'b1 || count !== (BYP ? 0 : 1)) begin
        bad++; $display("FAIL stream got v=%0b count=%0d", outValid, count);
      end
    end
  endtask

  task automatic test_hold();
    restart();
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, 1'b1);
    total++;
    if (count !== DEPTH || imemReq !== 1'b0 || imemAddr !== RST_PC + 32'd4) begin
      bad++; $display("FAIL hold_full got c=%0d req=%0b addr=%h exp 4/0/%h", count, imemReq, imemAddr, RST_PC + 32'd4);
    end
    drive_cycle(1'b0, '0, 1'b0);
    total++;
    if (count !== 3 || imemReq !== 1'b1) begin
      bad++; $display("FAIL hold_resume got c=%0d req=%0b exp 3/1", count, imemReq);
    end
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, 1'b0);
    total++;
    if (expPC !== RST_PC + 32'd9) begin bad++; $display("FAIL hold_drain got=%h exp=%h", expPC, RST_PC + 32'd9); end
  endtask

  task automatic test_redirect_pending();
    for (int i = 0; i < 8 && count != 3; i++) drive_cycle(1'b0, '0, 1'b1);
    total++;
    if (count !== 3 || imemReq !== 1'b0) begin
      bad++; $display("FAIL redir_setup got c=%0d req=%0b exp 3/0", count, imemReq);
    end
    drive_cycle(1'b1, 32'h40, 1'b1);
    total++;
    if (count !== '0 || outValid !== 1'b0) begin
      bad++; $display("FAIL redir_r got c=%0d v=%0b exp 0/0", count, outValid);
    end
    drive_cycle(1'b0, '0, 1'b0);
    total++;
    if (outValid !== BYP || count !== '0) begin
      bad++; $display("FAIL redir_r1 got v=%0b c=%0d exp %0b/0", outValid, count, BYP);
    end
    drive_cycle(1'b0, '0, 1'b0);
    total++;
    if (outValid !== 1'b1 || outPCPlus1 !== (BYP ? 32'h42 : 32'h41)) begin
      bad++; $display("FAIL redir_r2 got v=%0b pc1=%h", outValid, outPCPlus1);
    end
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_redirect_dequeue();
    logic found = 1'b0;
    logic [31:0] got = '0;
    total++;
    if (outValid !== 1'b1) begin bad++; $display("FAIL rdq_setup got v=%0b exp 1", outValid); end
    drive_cycle(1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 4; i++)
      if (!found) begin
        drive_cycle(1'b0, '0, 1'b0);
        if (outValid) begin found = 1'b1; got = outPCPlus1; end
      end
    total++;
    if (!found || got !== 32'h101) begin bad++; $display("FAIL rdq_first got found=%0b pc1=%h exp 1/101", found, got); end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0);
    #2 reset = 1'b0;
    #1;
    total++;
    if (outValid !== 1'b0 || count !== '0 || imemReq !== 1'b0 || imemAddr !== RST_PC) begin
      bad++; $display("FAIL areset_ctrl got v=%0b c=%0d req=%0b addr=%h", outValid, count, imemReq, imemAddr);
    end
    total++;
    if (outInstruction !== '0 || outPCPlus1 !== '0) begin
      bad++; $display("FAIL areset_data got=%h/%h exp=0/0", outInstruction, outPCPlus1);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    expPC = RST_PC;
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, 1'b0);
    total++;
    if (expPC !== RST_PC + (BYP ? 32'd7 : 32'd6)) begin
      bad++; $display("FAIL areset_restart got=%h exp=%h", expPC, RST_PC + (BYP ? 32'd7 : 32'd6));
    end
  endtask

  task automatic test_random();
    logic [31:0] start = expPC;
    int redirects = 0;
    for (int i = 0; i < 400; i++) begin
      logic r = $urandom_range(0, 19) == 0;
      logic [31:0] t = $urandom_range(0, 1) ? 32'hFFFFFFFE : $urandom;
      redirects += r;
      drive_cycle(r, t, $urandom_range(0, 9) < 4);
    end
    total++;
    if (redirects == 0 && expPC == start) begin bad++; $display("FAIL random_progress got=%h", expPC); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_startup();
    test_hold();
    test_redirect_pending();
    test_redirect_dequeue();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
